// File: rtl/qoa_spi_master.sv
// qoa_spi_master: SPI mode-0 initiator that sends one byte per transaction,
// MSB first and full duplex. Chip select can be held low between bytes.
module qoa_spi_master #(
   parameter int CLK_DIV  = 4,  // SPI half-period in sclk cycles (>= 1)
   parameter int CS_SETUP = 2   // cs_n fall to first half-period count (>= 1)
) (
   input  logic       sclk,
   input  logic       rst_n,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   input  logic       hold_cs,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       spi_sck,
   output logic       spi_cs_n,
   output logic       spi_mosi,
   input  logic       spi_miso
);

   typedef enum logic [1:0] {IDLE, SETUP, SHIFT} state_t;

   state_t      state_q, state_d;
   logic [7:0]  tx_sh, rx_sh;
   logic        hold_q;
   logic [15:0] div_cnt, setup_cnt;
   logic [3:0]  half_cnt;

   logic accept, setup_done, tick, rise, last;

   // Handshake and divider events, all from registered state.
   always_comb begin
      accept     = tx_valid && tx_ready;
      setup_done = (state_q == SETUP) && (setup_cnt == 16'(CS_SETUP - 1));
      tick       = (state_q == SHIFT) && (div_cnt == 16'(CLK_DIV - 1));
      rise       = tick && !spi_sck;
      last       = tick && spi_sck && (half_cnt == 4'd15);
   end

   // Next-state logic: a held cs_n skips the setup gap.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = spi_cs_n ? SETUP : SHIFT;
         SETUP:   if (setup_done) state_d = SHIFT;
         SHIFT:   if (last) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State register; reset abandons any transfer in flight.
   always_ff @(posedge sclk) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Datapath: shift registers, divider, half-period count and SPI pins.
   always_ff @(posedge sclk) begin
      if (!rst_n) begin
         tx_sh     <= '0;
         rx_sh     <= '0;
         hold_q    <= 1'b0;
         div_cnt   <= '0;
         setup_cnt <= '0;
         half_cnt  <= '0;
         tx_ready  <= 1'b1;
         rx_data   <= '0;
         rx_valid  <= 1'b0;
         spi_sck   <= 1'b0;
         spi_cs_n  <= 1'b1;
         spi_mosi  <= 1'b0;
      end else begin
         rx_valid <= 1'b0;
         case (state_q)
            IDLE: begin
               if (accept) begin
                  tx_sh     <= tx_data;
                  hold_q    <= hold_cs;
                  tx_ready  <= 1'b0;
                  spi_mosi  <= tx_data[7];
                  spi_cs_n  <= 1'b0;
                  setup_cnt <= '0;
                  div_cnt   <= '0;
                  half_cnt  <= '0;
               end else if (!hold_cs) begin
                  // A held frame is closed as soon as the host stops asking for it.
                  spi_cs_n <= 1'b1;
               end
            end
            SETUP: setup_cnt <= setup_cnt + 16'd1;
            SHIFT: begin
               if (tick) begin
                  div_cnt  <= '0;
                  spi_sck  <= ~spi_sck;
                  half_cnt <= half_cnt + 4'd1;
                  if (rise) begin
                     rx_sh <= {rx_sh[6:0], spi_miso};
                  end else if (last) begin
                     // 8th falling edge: byte complete, mosi keeps its last bit.
                     rx_data  <= rx_sh;
                     rx_valid <= 1'b1;
                     tx_ready <= 1'b1;
                     if (!hold_q) spi_cs_n <= 1'b1;
                  end else begin
                     tx_sh    <= {tx_sh[6:0], 1'b0};
                     spi_mosi <= tx_sh[6];
                  end
               end else begin
                  div_cnt <= div_cnt + 16'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
